// File: rtl/axi_stream_extract_header_if.sv
`default_nettype none
// ============================================================================
// Module : axi_stream_extract_header_if
// Input stream, header channel and re-aligned payload channel of the header
// extractor, bundled with master (environment) and slave (extractor) views.
// Rev    : 1.0
// ============================================================================
interface axi_stream_extract_header_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;
    logic [BYTE_CNT_WD:0]    byte_extract_cnt;

    logic                    valid_header;
    logic [DATA_WD-1:0]      data_header;
    logic [DATA_BYTE_WD-1:0] keep_header;
    logic                    ready_header;

    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;

    modport slave (
        input  valid_in, data_in, keep_in, last_in, byte_extract_cnt,
        input  ready_header, ready_out,
        output ready_in,
        output valid_header, data_header, keep_header,
        output valid_out, data_out, keep_out, last_out
    );

    modport master (
        output valid_in, data_in, keep_in, last_in, byte_extract_cnt,
        output ready_header, ready_out,
        input  ready_in,
        input  valid_header, data_header, keep_header,
        input  valid_out, data_out, keep_out, last_out
    );
endinterface
`default_nettype wire

// File: rtl/axi_stream_extract_header.sv
`default_nettype none
// ============================================================================
// Module : axi_stream_extract_header
// Strips the first N bytes of each packet onto a header channel and re-aligns
// the payload to the MSB lane. Define AXIS_EXTRACT_ERR_EN to add err_short.
// Rev    : 1.0
// ============================================================================
module axi_stream_extract_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  wire logic clk,
    input  wire logic rst_n,
`ifdef AXIS_EXTRACT_ERR_EN
    output logic      err_short,
`endif
    axi_stream_extract_header_if.slave bus
);
    localparam int              c_CW    = BYTE_CNT_WD + 1;
    localparam logic [c_CW-1:0] c_BYTES = c_CW'(DATA_BYTE_WD);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BODY  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]              r_state, w_state_nxt;
    logic [c_CW-1:0]         r_n, r_k, w_n_in, w_n_cur, w_k;
    logic [DATA_WD-1:0]      r_res;
    logic                    w_out_free, w_hdr_free, w_acc, w_short;
    logic                    w_hdr_load, w_pay_load, w_pay_last;
    logic [DATA_WD-1:0]      w_hdr_data, w_pay_data;
    logic [DATA_BYTE_WD-1:0] w_hdr_keep, w_pay_keep;

    function automatic logic [DATA_WD-1:0] shl_bytes(input logic [DATA_WD-1:0] d,
                                                     input logic [c_CW-1:0] b);
        return d << {b, 3'b000};
    endfunction

    function automatic logic [DATA_WD-1:0] shr_bytes(input logic [DATA_WD-1:0] d,
                                                     input logic [c_CW-1:0] b);
        return d >> {b, 3'b000};
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] top_mask(input logic [c_CW-1:0] m);
        logic [DATA_BYTE_WD-1:0] ones;
        ones = '1;
        return ~(ones >> m);
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] low_mask(input logic [c_CW-1:0] m);
        logic [DATA_BYTE_WD-1:0] ones;
        ones = '1;
        return ~(ones << m);
    endfunction

    // Zero or oversized header lengths collapse to a whole beat
    assign w_n_in = (bus.byte_extract_cnt == '0 || bus.byte_extract_cnt > c_BYTES)
                  ? c_BYTES : bus.byte_extract_cnt;
    assign w_n_cur    = (r_state == c_IDLE) ? w_n_in : r_n;
    assign w_short    = w_k < w_n_cur;
    assign w_out_free = !bus.valid_out || bus.ready_out;
    assign w_hdr_free = !bus.valid_header || bus.ready_header;
    assign w_acc      = bus.valid_in && bus.ready_in;

    always_comb begin
        w_k = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            w_k = w_k + {{(c_CW-1){1'b0}}, bus.keep_in[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_acc && !bus.last_in) w_state_nxt = c_BODY;
            c_BODY:  if (w_acc && bus.last_in)  w_state_nxt = (w_k > r_n) ? c_DRAIN : c_IDLE;
            c_DRAIN: if (w_out_free)            w_state_nxt = c_IDLE;
            default:                            w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        bus.ready_in = 1'b0;
        w_hdr_load   = 1'b0;
        w_hdr_data   = '0;
        w_hdr_keep   = '0;
        w_pay_load   = 1'b0;
        w_pay_data   = '0;
        w_pay_keep   = '0;
        w_pay_last   = 1'b0;
        case (r_state)
            c_IDLE: begin
                // A first beat may load both registers, so both slots must be free
                bus.ready_in = w_out_free && w_hdr_free;
                if (bus.valid_in && bus.ready_in) begin
                    w_hdr_load = 1'b1;
                    if (bus.last_in && w_short) begin
                        w_hdr_data = shr_bytes(bus.data_in, c_BYTES - w_k);
                        w_hdr_keep = low_mask(w_k);
                    end else begin
                        w_hdr_data = shr_bytes(bus.data_in, c_BYTES - w_n_cur);
                        w_hdr_keep = low_mask(w_n_cur);
                    end
                    if (bus.last_in && w_k > w_n_cur) begin
                        w_pay_load = 1'b1;
                        w_pay_data = shl_bytes(bus.data_in, w_n_cur);
                        w_pay_keep = top_mask(w_k - w_n_cur);
                        w_pay_last = 1'b1;
                    end
                end
            end
            c_BODY: begin
                bus.ready_in = w_out_free;
                if (bus.valid_in && bus.ready_in) begin
                    w_pay_load = 1'b1;
                    w_pay_data = r_res | shr_bytes(bus.data_in, c_BYTES - r_n);
                    w_pay_keep = '1;
                    if (bus.last_in && w_k <= r_n) begin
                        w_pay_keep = top_mask(c_BYTES - r_n + w_k);
                        w_pay_last = 1'b1;
                    end
                end
            end
            c_DRAIN: begin
                if (w_out_free) begin
                    w_pay_load = 1'b1;
                    w_pay_data = r_res;
                    w_pay_keep = top_mask(r_k - r_n);
                    w_pay_last = 1'b1;
                end
            end
            default: bus.ready_in = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid_header <= 1'b0;
            bus.data_header  <= '0;
            bus.keep_header  <= '0;
            bus.valid_out    <= 1'b0;
            bus.data_out     <= '0;
            bus.keep_out     <= '0;
            bus.last_out     <= 1'b0;
            r_res            <= '0;
            r_n              <= '0;
            r_k              <= '0;
        end else begin
            if (w_hdr_load) begin
                bus.valid_header <= 1'b1;
                bus.data_header  <= w_hdr_data;
                bus.keep_header  <= w_hdr_keep;
            end else if (bus.ready_header) begin
                bus.valid_header <= 1'b0;
            end
            if (w_pay_load) begin
                bus.valid_out <= 1'b1;
                bus.data_out  <= w_pay_data;
                bus.keep_out  <= w_pay_keep;
                bus.last_out  <= w_pay_last;
            end else if (bus.ready_out) begin
                bus.valid_out <= 1'b0;
            end
            // Residual is kept left-aligned so it ORs straight into the next beat
            if (w_acc) r_res <= shl_bytes(bus.data_in, w_n_cur);
            if (w_acc && r_state == c_IDLE) r_n <= w_n_in;
            if (w_acc && bus.last_in) r_k <= w_k;
        end
    end

`ifdef AXIS_EXTRACT_ERR_EN
    logic w_cnt_bad;
    assign w_cnt_bad = (bus.byte_extract_cnt == '0) || (bus.byte_extract_cnt > c_BYTES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_short <= 1'b0;
        else        err_short <= w_hdr_load && ((bus.last_in && w_short) || w_cnt_bad);
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_axi_stream_extract_header.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_stream_extract_header
// Directed bench for the header extractor with hand-computed expected beats.
// Rev    : 1.0
// ============================================================================
module tb_axi_stream_extract_header;
    logic clk;
    logic rst_n;
`ifdef AXIS_EXTRACT_ERR_EN
    logic err_short;
`endif

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t hdr_q[$];
    beat_t pay_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    axi_stream_extract_header_if #(.DATA_WD(32)) bus ();

    axi_stream_extract_header #(.DATA_WD(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef AXIS_EXTRACT_ERR_EN
        .err_short(err_short),
`endif
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic exp_hdr(input logic [31:0] d, input logic [3:0] k);
        hdr_q.push_back('{d: d, k: k, l: 1'b0});
    endtask

    task automatic exp_pay(input logic [31:0] d, input logic [3:0] k, input logic l);
        pay_q.push_back('{d: d, k: k, l: l});
    endtask

    // Drive one beat and wait (bounded) for it to be accepted; returns cycles taken
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l,
                        input logic [2:0] n, output int cyc);
        bit acc;
        bus.valid_in         = 1'b1;
        bus.data_in          = d;
        bus.keep_in          = k;
        bus.last_in          = l;
        bus.byte_extract_cnt = n;
        cyc = 0;
        acc = 1'b0;
        while (!acc && cyc < 20) begin
            @(negedge clk);
            acc = bus.ready_in;
            @(posedge clk);
            #2;
            cyc++;
        end
        if (!acc) check_val("accept_timeout", 32'd0, 32'd1);
        bus.valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Output monitor: scoreboards both channels and checks stall stability
    logic [31:0] held_d;
    logic [3:0]  held_k;
    bit          stalled = 1'b0;
    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check_val("stall_valid", {31'd0, bus.valid_out}, 32'd1);
                check_val("stall_data", bus.data_out, held_d);
                check_val("stall_keep", {28'd0, bus.keep_out}, {28'd0, held_k});
            end
            stalled = bus.valid_out && !bus.ready_out;
            held_d  = bus.data_out;
            held_k  = bus.keep_out;
            if (bus.valid_header && bus.ready_header) begin
                if (hdr_q.size() == 0) check_val("hdr_unexpected", 32'd1, 32'd0);
                else begin
                    b = hdr_q.pop_front();
                    check_val("hdr_data", bus.data_header, b.d);
                    check_val("hdr_keep", {28'd0, bus.keep_header}, {28'd0, b.k});
                end
            end
            if (bus.valid_out && bus.ready_out) begin
                if (pay_q.size() == 0) check_val("pay_unexpected", 32'd1, 32'd0);
                else begin
                    b = pay_q.pop_front();
                    check_val("pay_data", bus.data_out, b.d);
                    check_val("pay_keep", {28'd0, bus.keep_out}, {28'd0, b.k});
                    check_val("pay_last", {31'd0, bus.last_out}, {31'd0, b.l});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n                = 1'b0;
        bus.valid_in         = 1'b0;
        bus.data_in          = '0;
        bus.keep_in          = '0;
        bus.last_in          = 1'b0;
        bus.byte_extract_cnt = '0;
        bus.ready_header     = 1'b1;
        bus.ready_out        = 1'b1;
        idle(3);
        check_val("rst_valid_header", {31'd0, bus.valid_header}, 32'd0);
        check_val("rst_valid_out", {31'd0, bus.valid_out}, 32'd0);
        check_val("rst_last_out", {31'd0, bus.last_out}, 32'd0);
        check_val("rst_data_header", bus.data_header, 32'd0);
        check_val("rst_keep_header", {28'd0, bus.keep_header}, 32'd0);
        check_val("rst_data_out", bus.data_out, 32'd0);
        check_val("rst_keep_out", {28'd0, bus.keep_out}, 32'd0);
        rst_n = 1'b1;
        idle(1);
        check_val("idle_ready_in", {31'd0, bus.ready_in}, 32'd1);

        // N=2, last beat full: one full beat then a drain beat
        exp_hdr(32'h0000AABB, 4'h3);
        exp_pay(32'hCCDD1122, 4'hF, 1'b0);
        exp_pay(32'h33445566, 4'hF, 1'b0);
        exp_pay(32'h77880000, 4'hC, 1'b1);
        send(32'hAABBCCDD, 4'hF, 1'b0, 3'd2, c);
        send(32'h11223344, 4'hF, 1'b0, 3'd2, c);
        send(32'h55667788, 4'hF, 1'b1, 3'd2, c);
        idle(3);

        // N=1, last beat keep E: ready_in low in the drain cycle
        exp_hdr(32'h00000001, 4'h1);
        exp_pay(32'h23456789, 4'hF, 1'b0);
        exp_pay(32'hABCDEF13, 4'hF, 1'b0);
        exp_pay(32'h579B0000, 4'hC, 1'b1);
        send(32'h01234567, 4'hF, 1'b0, 3'd1, c);
        send(32'h89ABCDEF, 4'hF, 1'b0, 3'd1, c);
        send(32'h13579B00, 4'hE, 1'b1, 3'd1, c);
        @(negedge clk);
        check_val("drain_ready_in", {31'd0, bus.ready_in}, 32'd0);
        idle(3);

        // N=W: payload is the input delayed, no drain
        exp_hdr(32'h01020304, 4'hF);
        exp_pay(32'h05060708, 4'hF, 1'b1);
        send(32'h01020304, 4'hF, 1'b0, 3'd4, c);
        send(32'h05060708, 4'hF, 1'b1, 3'd4, c);
        check_val("nw_next_accept_ready", {31'd0, bus.ready_in}, 32'd1);
        idle(3);

        // Short single-beat packet, then clamped lengths 0 and 6, then K>N single beat
        exp_hdr(32'h0000005A, 4'h1);
        send(32'h5A000000, 4'h8, 1'b1, 3'd3, c);
`ifdef AXIS_EXTRACT_ERR_EN
        check_val("err_short_k_lt_n", {31'd0, err_short}, 32'd1);
`endif
        idle(1);
        check_val("short_no_payload", {31'd0, bus.valid_out}, 32'd0);
`ifdef AXIS_EXTRACT_ERR_EN
        check_val("err_short_pulse_end", {31'd0, err_short}, 32'd0);
`endif
        exp_hdr(32'hDEADBEEF, 4'hF);
        send(32'hDEADBEEF, 4'hF, 1'b1, 3'd0, c);
`ifdef AXIS_EXTRACT_ERR_EN
        check_val("err_short_cnt0", {31'd0, err_short}, 32'd1);
`endif
        exp_hdr(32'hCAFEF00D, 4'hF);
        send(32'hCAFEF00D, 4'hF, 1'b1, 3'd6, c);
`ifdef AXIS_EXTRACT_ERR_EN
        check_val("err_short_cnt6", {31'd0, err_short}, 32'd1);
`endif
        exp_hdr(32'h000000A1, 4'h1);
        exp_pay(32'hB2000000, 4'h8, 1'b1);
        send(32'hA1B20000, 4'hC, 1'b1, 3'd1, c);
`ifdef AXIS_EXTRACT_ERR_EN
        check_val("err_short_none", {31'd0, err_short}, 32'd0);
`endif
        idle(3);

        // Payload backpressure: ready_out low for 3 cycles mid-packet
        exp_hdr(32'h00001020, 4'h3);
        exp_pay(32'h30405060, 4'hF, 1'b0);
        exp_pay(32'h708090A0, 4'hF, 1'b0);
        exp_pay(32'hB0C0D0E0, 4'hF, 1'b1);
        fork
            begin
                send(32'h10203040, 4'hF, 1'b0, 3'd2, c);
                send(32'h50607080, 4'hF, 1'b0, 3'd2, c);
                send(32'h90A0B0C0, 4'hF, 1'b0, 3'd2, c);
                send(32'hD0E00000, 4'hC, 1'b1, 3'd2, c);
            end
            begin
                repeat (2) @(posedge clk);
                #2 bus.ready_out = 1'b0;
                repeat (3) @(posedge clk);
                #2 bus.ready_out = 1'b1;
            end
        join
        idle(3);

        // Header stall across a packet boundary
        bus.ready_header = 1'b0;
        exp_hdr(32'h11111111, 4'hF);
        exp_pay(32'h22222222, 4'hF, 1'b1);
        send(32'h11111111, 4'hF, 1'b0, 3'd4, c);
        send(32'h22222222, 4'hF, 1'b1, 3'd4, c);
        check_val("hdr_stall_payload_flows", c, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("hdr_stall_blocks_first", {31'd0, bus.ready_in}, 32'd0);
        end
        @(posedge clk);
        #2 bus.ready_header = 1'b1;
        exp_hdr(32'h00003344, 4'h3);
        send(32'h33440000, 4'hC, 1'b1, 3'd2, c);
        idle(3);

        // Back-to-back packets: only the drain cycle may insert a bubble
        exp_hdr(32'h0000A0A1, 4'h3);
        exp_pay(32'hA2A3B0B1, 4'hF, 1'b0);
        exp_pay(32'hB2B30000, 4'hC, 1'b1);
        exp_hdr(32'h00C0C1C2, 4'h7);
        exp_pay(32'hC3D0D1D2, 4'hF, 1'b0);
        exp_pay(32'hD3000000, 4'h8, 1'b1);
        send(32'hA0A1A2A3, 4'hF, 1'b0, 3'd2, c);
        send(32'hB0B1B2B3, 4'hF, 1'b1, 3'd2, c);
        check_val("b2b_p1_beat2_cycles", c, 32'd1);
        send(32'hC0C1C2C3, 4'hF, 1'b0, 3'd3, c);
        check_val("b2b_after_drain_cycles", c, 32'd2);
        send(32'hD0D1D2D3, 4'hF, 1'b1, 3'd3, c);
        check_val("b2b_p2_beat2_cycles", c, 32'd1);
        idle(3);

        // Reset mid-packet, then a clean packet
        exp_hdr(32'h00000A0B, 4'h3);
        send(32'h0A0B0C0D, 4'hF, 1'b0, 3'd2, c);
        send(32'h1A1B1C1D, 4'hF, 1'b0, 3'd2, c);
        rst_n = 1'b0;
        #1;
        check_val("midrst_valid_out", {31'd0, bus.valid_out}, 32'd0);
        check_val("midrst_valid_header", {31'd0, bus.valid_header}, 32'd0);
        check_val("midrst_last_out", {31'd0, bus.last_out}, 32'd0);
        hdr_q.delete();
        pay_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check_val("post_rst_ready_in", {31'd0, bus.ready_in}, 32'd1);
        exp_hdr(32'h55AA55AA, 4'hF);
        exp_pay(32'h12345678, 4'hF, 1'b1);
        send(32'h55AA55AA, 4'hF, 1'b0, 3'd4, c);
        send(32'h12345678, 4'hF, 1'b1, 3'd4, c);
        idle(5);

        check_val("hdr_queue_drained", hdr_q.size(), 32'd0);
        check_val("pay_queue_drained", pay_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
